instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Instruction-pointer and fetch sequencer for one distributed-processor core; sits directly upstream of the opcode decoder.
- Owns the instruction pointer and issues command-memory reads.
- Presents each fetched instruction word, and its opcode byte, to the decoder for one cycle.
- Applies the decoder's pointer-load and pointer-enable selects to choose the next address, stalling on pulse-trigger, sync or fproc conditions.

Parameters:
MEM_ADDR_W, 8, command-memory address width (instruction pointer width)
INSTR_W, 128, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-8]

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run control; low forces IDLE and pointer clear
mem_addr  out  MEM_ADDR_W  command-memory read address (registered, equals instr_ptr)
mem_data  in  INSTR_W  synchronous-read memory data, valid one cycle after address sampled
instr  out  INSTR_W  held instruction register
opcode  out  8  instr[INSTR_W-1:INSTR_W-8], to decoder
instr_valid  out  1  high exactly one cycle per instruction (EXEC)
inst_ptr_load_en  in  2  from decoder: 00 increment, 01 jump, 10 conditional jump on alu_cond, 11 reserved
inst_ptr_en_sel  in  3  from decoder: 0 advance now, 1 wait pulse_trig_ready, 2 wait sync_in_valid, 3 wait fproc_in_valid, others reserved
jump_addr  in  MEM_ADDR_W  jump target from instruction field
alu_cond  in  1  ALU compare result (bit 0)
halt  in  1  decoder flags done instruction
pulse_trig_ready  in  1  qclk reached pulse time
sync_in_valid  in  1  sync barrier released
fproc_in_valid  in  1  fproc result available
done  out  1  core halted
err  out  1  sticky: reserved load_en or en_sel decoded

Behaviour:
- Reset (rst_n low, async):
  - instr_ptr=0, mem_addr=0, instr=0, instr_valid=0, done=0, err=0, state=IDLE.
- States: IDLE, FETCH, LOAD, EXEC, WAIT, HALT.
  - IDLE: instr_ptr held at 0; enable=1 -> FETCH.
  - FETCH: mem_addr=instr_ptr presented; RAM samples it at the end of this cycle -> LOAD.
  - LOAD: mem_data valid; captured into instr at the end of the cycle -> EXEC.
  - EXEC: instr_valid=1; decoder outputs are combinational from opcode and sampled this cycle.
    - halt=1 -> HALT; pointer unchanged.
    - Wait condition true (en_sel 0, or the selected input already high) -> pointer update, FETCH.
    - Wait condition false -> latch load_en, en_sel, jump_addr, alu_cond; -> WAIT.
  - WAIT: instr held, instr_valid=0.
    - Each cycle, test the latched condition against the live input.
    - When true: update pointer from the latched fields -> FETCH.
  - HALT: done=1; remains until enable=0.
- Pointer update:
  - 00 -> ptr+1.
  - 01 -> jump_addr.
  - 10 -> alu_cond ? jump_addr : ptr+1.
  - 11 -> ptr+1 and err<=1.
- Reserved en_sel (4-7) is treated as 0 and sets err.
- Increment wraps modulo 2^MEM_ADDR_W (max -> 0); wrap is silent.
- Latency: a non-stalled instruction takes exactly 3 cycles (FETCH, LOAD, EXEC).
  - EXEC-to-EXEC spacing is 3 cycles.
  - A stall adds N cycles, where N is the number of WAIT cycles before the condition is seen high.
- A wait input high in the same cycle the state enters WAIT is honoured on that cycle (minimum 1 WAIT cycle).
- Jump to the current address (self-loop) is legal; it refetches.
- enable=0 in any state: next edge -> IDLE, instr_ptr=0, instr_valid=0, done=0. err is not cleared (reset only).
- enable=0 and halt=1 in the same EXEC cycle: enable wins -> IDLE.
- Async reset mid-WAIT or mid-LOAD: immediate return to reset values; no partial instruction retained.

Test Plan:
- Run 3 sequential non-jump instructions from address 0 -> mem_addr 0,1,2; instr_valid pulses 3 cycles apart; opcode matches mem_data top byte.
- EXEC at ptr 5 with load_en=01, jump_addr=0x40 -> next mem_addr=0x40; with load_en=10, alu_cond=0 -> 6; alu_cond=1 -> 0x40.
- en_sel=1, pulse_trig_ready rises 7 cycles after EXEC -> 7 WAIT cycles, FETCH of ptr+1 on the next cycle; instr_valid stays low throughout the wait.
- Conditional jump with en_sel=3; alu_cond toggles 1->0 during WAIT -> jump is taken using the latched value 1 once fproc_in_valid=1.
- ptr=0xFF, load_en=00 -> mem_addr wraps to 0x00; load_en=11 -> err=1, stays 1 after enable toggle.
- halt at ptr 0x10 -> done=1 held; drop enable -> IDLE, mem_addr=0; rst_n pulse during WAIT -> all outputs zero within the same cycle.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Instruction pointer and fetch sequencer for one core.
// Walks FETCH/LOAD/EXEC and stalls in WAIT on trigger, sync or fproc inputs.
module instr_fetch_seq #(
    parameter int MEM_ADDR_W = 8,
    parameter int INSTR_W    = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [INSTR_W-1:0]    mem_data,
    output logic [INSTR_W-1:0]    instr,
    output logic [7:0]            opcode,
    output logic                  instr_valid,
    input  logic [1:0]            inst_ptr_load_en,
    input  logic [2:0]            inst_ptr_en_sel,
    input  logic [MEM_ADDR_W-1:0] jump_addr,
    input  logic                  alu_cond,
    input  logic                  halt,
    input  logic                  pulse_trig_ready,
    input  logic                  sync_in_valid,
    input  logic                  fproc_in_valid,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, EXEC, WAIT, HALT
    } state_e;

    state_e                state_q, state_d;
    logic [MEM_ADDR_W-1:0] ptr_q, ptr_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic [1:0]            load_q, load_d;
    logic [2:0]            sel_q, sel_d;
    logic [MEM_ADDR_W-1:0] jump_q, jump_d;
    logic                  alu_q, alu_d;
    logic                  err_q, err_d;

    logic [1:0]            cur_load;
    logic [2:0]            cur_sel;
    logic [MEM_ADDR_W-1:0] cur_jump;
    logic                  cur_alu;
    logic                  go;
    logic [MEM_ADDR_W-1:0] next_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            instr_q <= '0;
            load_q  <= '0;
            sel_q   <= '0;
            jump_q  <= '0;
            alu_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
            load_q  <= load_d;
            sel_q   <= sel_d;
            jump_q  <= jump_d;
            alu_q   <= alu_d;
            err_q   <= err_d;
        end
    end

    // EXEC decides on the live decoder fields, WAIT on the latched copy
    always_comb begin
        cur_load = inst_ptr_load_en;
        cur_sel  = inst_ptr_en_sel;
        cur_jump = jump_addr;
        cur_alu  = alu_cond;
        if (state_q == WAIT) begin
            cur_load = load_q;
            cur_sel  = sel_q;
            cur_jump = jump_q;
            cur_alu  = alu_q;
        end
    end

    always_comb begin
        go = 1'b1;
        case (cur_sel)
            3'd1:    go = pulse_trig_ready;
            3'd2:    go = sync_in_valid;
            3'd3:    go = fproc_in_valid;
            default: go = 1'b1;
        endcase
    end

    always_comb begin
        next_ptr = ptr_q + MEM_ADDR_W'(1);
        case (cur_load)
            2'b01:   next_ptr = cur_jump;
            2'b10:   next_ptr = cur_alu ? cur_jump : ptr_q + MEM_ADDR_W'(1);
            default: next_ptr = ptr_q + MEM_ADDR_W'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        instr_d = instr_q;
        load_d  = load_q;
        sel_d   = sel_q;
        jump_d  = jump_q;
        alu_d   = alu_q;
        err_d   = err_q;
        if (!enable) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ptr_d   = '0;
                    state_d = FETCH;
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    instr_d = mem_data;
                    state_d = EXEC;
                end
                EXEC: begin
                    if (halt) begin
                        state_d = HALT;
                    end else begin
                        if (cur_load == 2'b11 || cur_sel[2])
                            err_d = 1'b1;
                        if (go) begin
                            ptr_d   = next_ptr;
                            state_d = FETCH;
                        end else begin
                            load_d  = cur_load;
                            sel_d   = cur_sel;
                            jump_d  = cur_jump;
                            alu_d   = cur_alu;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (go) begin
                        ptr_d   = next_ptr;
                        state_d = FETCH;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    assign mem_addr    = ptr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[INSTR_W-1 -: 8];
    assign instr_valid = (state_q == EXEC);
    assign done        = (state_q == HALT);
    assign err         = err_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with an EXEC scoreboard.
module tb_instr_fetch_seq;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic [7:0]   mem_addr;
    logic [127:0] mem_data;
    logic [127:0] instr;
    logic [7:0]   opcode;
    logic         instr_valid;
    logic [1:0]   inst_ptr_load_en;
    logic [2:0]   inst_ptr_en_sel;
    logic [7:0]   jump_addr;
    logic         alu_cond;
    logic         halt;
    logic         pulse_trig_ready;
    logic         sync_in_valid;
    logic         fproc_in_valid;
    logic         done;
    logic         err;

    typedef struct {
        logic [7:0]   addr;
        logic [127:0] word;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] mem[256];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;

    instr_fetch_seq #(.MEM_ADDR_W(8), .INSTR_W(128)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .instr(instr),
        .opcode(opcode),
        .instr_valid(instr_valid),
        .inst_ptr_load_en(inst_ptr_load_en),
        .inst_ptr_en_sel(inst_ptr_en_sel),
        .jump_addr(jump_addr),
        .alu_cond(alu_cond),
        .halt(halt),
        .pulse_trig_ready(pulse_trig_ready),
        .sync_in_valid(sync_in_valid),
        .fproc_in_valid(fproc_in_valid),
        .done(done),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read command memory
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard consumer: every EXEC must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid === 1'b1) begin
            chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("exec_addr", 128'(mem_addr), 128'(e.addr));
                chk("exec_instr", instr, e.word);
                chk("exec_opcode", 128'(opcode), 128'(e.word[127:120]));
            end
        end
    end

    task automatic dec(input logic [1:0] le, input logic [2:0] es,
                       input logic [7:0] ja, input logic ac,
                       input logic h);
        inst_ptr_load_en = le;
        inst_ptr_en_sel  = es;
        jump_addr        = ja;
        alu_cond         = ac;
        halt             = h;
    endtask

    task automatic exec_wait(input logic [7:0] a, output int at);
        exp_t e;
        e.addr = a;
        e.word = mem[a];
        sb.push_back(e);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) break;
        end
        chk("exec_seen", 128'(instr_valid), 128'd1);
        at = cyc;
    endtask

    int t0, t1, t2;

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        rst_n            = 1'b0;
        enable           = 1'b0;
        pulse_trig_ready = 1'b0;
        sync_in_valid    = 1'b0;
        fproc_in_valid   = 1'b0;
        dec(2'b00, 3'd0, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        chk("rst_mem_addr", 128'(mem_addr), 128'd0);
        chk("rst_instr", instr, 128'd0);
        chk("rst_valid", 128'(instr_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        rst_n  = 1'b1;
        @(negedge clk);
        chk("idle_addr", 128'(mem_addr), 128'd0);
        enable = 1'b1;

        // sequential run
        exec_wait(8'h00, t0);
        exec_wait(8'h01, t1);
        exec_wait(8'h02, t2);
        chk("spacing_0_1", 128'(t1 - t0), 128'd3);
        chk("spacing_1_2", 128'(t2 - t1), 128'd3);
        exec_wait(8'h03, t0);
        exec_wait(8'h04, t0);
        exec_wait(8'h05, t0);

        // jump and conditional jump from ptr 5
        dec(2'b01, 3'd0, 8'h40, 1'b0, 1'b0);
        exec_wait(8'h40, t0);
        dec(2'b01, 3'd0, 8'h05, 1'b0, 1'b0);
        exec_wait(8'h05, t0);
        dec(2'b10, 3'd0, 8'h40, 1'b0, 1'b0);
        exec_wait(8'h06, t0);
        dec(2'b01, 3'd0, 8'h05, 1'b0, 1'b0);
        exec_wait(8'h05, t0);
        dec(2'b10, 3'd0, 8'h40, 1'b1, 1'b0);
        exec_wait(8'h40, t0);

        // stall on pulse trigger for 7 WAIT cycles
        dec(2'b00, 3'd1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("wait_valid_low", 128'(instr_valid), 128'd0);
            chk("wait_addr_hold", 128'(mem_addr), 128'h40);
            if (i == 7) pulse_trig_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_wait_fetch", 128'(mem_addr), 128'h41);
        pulse_trig_ready = 1'b0;
        exec_wait(8'h41, t1);
        chk("stall_spacing", 128'(t1 - t0), 128'd10);

        // latched alu_cond used after fproc wait
        dec(2'b10, 3'd3, 8'h20, 1'b1, 1'b0);
        @(negedge clk);
        alu_cond = 1'b0;
        chk("fproc_wait_low", 128'(instr_valid), 128'd0);
        @(negedge clk);
        fproc_in_valid = 1'b1;
        exec_wait(8'h20, t0);
        fproc_in_valid = 1'b0;

        // increment wrap and reserved load_en
        dec(2'b01, 3'd0, 8'hFF, 1'b0, 1'b0);
        exec_wait(8'hFF, t0);
        dec(2'b00, 3'd0, 8'h00, 1'b0, 1'b0);
        exec_wait(8'h00, t0);
        chk("err_clear_before", 128'(err), 128'd0);
        dec(2'b11, 3'd0, 8'h00, 1'b0, 1'b0);
        exec_wait(8'h01, t0);
        chk("err_set", 128'(err), 128'd1);
        dec(2'b00, 3'd0, 8'h00, 1'b0, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        chk("en_off_addr", 128'(mem_addr), 128'd0);
        chk("en_off_valid", 128'(instr_valid), 128'd0);
        chk("err_sticky", 128'(err), 128'd1);
        enable = 1'b1;
        exec_wait(8'h00, t0);

        // halt at 0x10
        dec(2'b01, 3'd0, 8'h10, 1'b0, 1'b0);
        exec_wait(8'h10, t0);
        dec(2'b00, 3'd0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("halt_done", 128'(done), 128'd1);
        repeat (3) @(negedge clk);
        chk("halt_done_held", 128'(done), 128'd1);
        chk("halt_addr_held", 128'(mem_addr), 128'h10);
        chk("halt_valid_low", 128'(instr_valid), 128'd0);
        enable = 1'b0;
        halt   = 1'b0;
        @(negedge clk);
        chk("unhalt_done", 128'(done), 128'd0);
        chk("unhalt_addr", 128'(mem_addr), 128'd0);
        enable = 1'b1;

        // enable drop beats halt in the same EXEC
        exec_wait(8'h00, t0);
        dec(2'b00, 3'd0, 8'h00, 1'b0, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk("en_beats_halt", 128'(done), 128'd0);
        halt   = 1'b0;
        enable = 1'b1;

        // async reset in the middle of WAIT
        exec_wait(8'h00, t0);
        dec(2'b00, 3'd2, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("sync_wait_low", 128'(instr_valid), 128'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", 128'(mem_addr), 128'd0);
        chk("arst_instr", instr, 128'd0);
        chk("arst_opcode", 128'(opcode), 128'd0);
        chk("arst_err", 128'(err), 128'd0);
        chk("arst_done", 128'(done), 128'd0);
        chk("arst_valid", 128'(instr_valid), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
